// File: rtl/muldiv_iter.sv
// Iterative unsigned multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, fixed 33-cycle latency from accept to the done pulse.
module muldiv_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result2
);

  localparam logic [3:0] OpMul = 4'h3;
  localparam logic [3:0] OpDiv = 4'h4;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_x;
  logic [WIDTH-1:0]   r_y;
  logic [2*WIDTH-1:0] r_acc;

  logic               w_accept;
  logic               w_last;
  logic [2*WIDTH-1:0] w_addend;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [CNT_W-1:0]   w_bit_idx;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_acc_next;

  always_comb begin
    w_accept   = start && !flush && ((op == OpMul) || (op == OpDiv));
    w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    w_addend   = r_y[r_cnt] ? ({{WIDTH{1'b0}}, r_x} << r_cnt) : '0;
    w_mul_next = r_acc + w_addend;
    // Divide: upper half is the partial remainder, quotient bits shift into the lower half.
    w_bit_idx  = CNT_W'(WIDTH - 1) - r_cnt;
    w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_x[w_bit_idx]};
    w_ge       = (w_shift >= {1'b0, r_y});
    w_diff     = w_ge ? (w_shift - {1'b0, r_y}) : w_shift;
    w_div_next = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], w_ge};
    w_acc_next = (r_op == OpMul) ? w_mul_next : w_div_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_op    <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_acc   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      result2 <= '0;
    end else begin
      case (r_state)
        StIdle, StDone: begin
          done <= 1'b0;
          if (w_accept) begin
            r_x     <= x;
            r_y     <= y;
            r_op    <= op;
            r_acc   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= StCalc;
          end else begin
            busy    <= 1'b0;
            r_state <= StIdle;
          end
        end
        StCalc: begin
          if (flush) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            r_state <= StIdle;
          end else begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              result  <= w_acc_next[WIDTH-1:0];
              result2 <= w_acc_next[2*WIDTH-1:WIDTH];
              busy    <= 1'b0;
              done    <= 1'b1;
              r_state <= StDone;
            end
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: directed and randomized ops against an
// arithmetic reference model, plus handshake, flush and reset scenarios.
module tb_muldiv_iter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [31:0] x;
  logic [31:0] y;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] result2;

  int unsigned n_vec;
  int unsigned n_err;
  logic [31:0] exp_lo;
  logic [31:0] exp_hi;

  muldiv_iter #(.WIDTH(32), .CNT_W(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .x      (x),
    .y      (y),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result),
    .result2(result2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_model(input logic [3:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] p;
    if (o == 4'h3) begin
      p = 64'(a) * 64'(b);
    end else if (b == 32'd0) begin
      p = {a, 32'hFFFF_FFFF};
    end else begin
      p = {a % b, a / b};
    end
    return p;
  endfunction

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit noise, input string name);
    logic [63:0] e;
    int unsigned bad;
    e     = ref_model(o, a, b);
    start = 1'b1;
    op    = o;
    x     = a;
    y     = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    bad   = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (busy !== 1'b1 || done !== 1'b0 || result !== exp_lo || result2 !== exp_hi) bad++;
      if (noise) begin
        x     = $urandom;
        y     = $urandom;
        op    = 4'($urandom_range(3, 4));
        start = 1'($urandom_range(0, 1));
      end
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL %s calc_phase: %0d bad cycles, required busy=1 done=0 results held", name,
               bad);
    end
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b1 || result !== e[31:0] || result2 !== e[63:32]) begin
      n_err++;
      $display("FAIL %s done: busy=%b done=%b lo=%h hi=%h, required busy=0 done=1 lo=%h hi=%h",
               name, busy, done, result, result2, e[31:0], e[63:32]);
    end
    exp_lo = e[31:0];
    exp_hi = e[63:32];
  endtask

  // Idle for n cycles: no busy, no done, results held.
  task automatic check_idle(input int n, input string name);
    int unsigned bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || result !== exp_lo || result2 !== exp_hi) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL %s idle: %0d bad cycles, required busy=0 done=0 lo=%h hi=%h", name, bad,
               exp_lo, exp_hi);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || result2 !== 32'd0) begin
      n_err++;
      $display("FAIL reset: busy=%b done=%b lo=%h hi=%h, required all 0", busy, done, result,
               result2);
    end
    rst    = 1'b0;
    exp_lo = '0;
    exp_hi = '0;
    check_idle(2, "reset");
  endtask

  task automatic test_mul();
    do_op(4'h3, 32'd7, 32'd6, 1'b0, "mul_basic");
    check_idle(1, "mul_basic");
    do_op(4'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mul_full");
    check_idle(1, "mul_full");
  endtask

  task automatic test_div();
    do_op(4'h4, 32'd100, 32'd7, 1'b0, "div_basic");
    check_idle(1, "div_basic");
    do_op(4'h4, 32'h1234_5678, 32'd0, 1'b0, "div_zero");
    check_idle(1, "div_zero");
  endtask

  task automatic test_ignored_op();
    start = 1'b1;
    op    = 4'h5;
    x     = 32'd9;
    y     = 32'd9;
    check_idle(1, "ignored_op5");
    op = 4'h0;
    check_idle(1, "ignored_op0");
    start = 1'b0;
    check_idle(3, "ignored_after");
  endtask

  task automatic test_start_during_calc();
    do_op(4'h3, 32'hDEAD_BEEF, 32'h0000_1234, 1'b1, "calc_start_mul");
    check_idle(1, "calc_start_mul");
    do_op(4'h4, 32'hCAFE_F00D, 32'd12345, 1'b1, "calc_start_div");
    check_idle(1, "calc_start_div");
  endtask

  task automatic test_back_to_back();
    do_op(4'h3, 32'd123456, 32'd654321, 1'b0, "b2b_first");
    do_op(4'h4, 32'hFFFF_FFFF, 32'd3, 1'b0, "b2b_second");
    do_op(4'h3, 32'h8000_0000, 32'd2, 1'b0, "b2b_third");
    check_idle(2, "b2b");
  endtask

  task automatic test_flush();
    start = 1'b1;
    op    = 4'h4;
    x     = 32'd999;
    y     = 32'd10;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) @(negedge clk);
    flush = 1'b1;
    start = 1'b1;
    op    = 4'h3;
    x     = 32'd5;
    y     = 32'd5;
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL flush_next: busy=%b done=%b, required busy=0 done=0", busy, done);
    end
    check_idle(40, "flush");
    do_op(4'h4, 32'd1000, 32'd33, 1'b0, "after_flush");
    check_idle(1, "after_flush");
  endtask

  task automatic test_rst_mid_calc();
    start = 1'b1;
    op    = 4'h3;
    x     = 32'hFFFF_0000;
    y     = 32'h0000_FFFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 15; i++) @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || result2 !== 32'd0) begin
      n_err++;
      $display("FAIL rst_mid: busy=%b done=%b lo=%h hi=%h, required all 0", busy, done, result,
               result2);
    end
    @(negedge clk);
    rst    = 1'b0;
    exp_lo = '0;
    exp_hi = '0;
    check_idle(40, "rst_mid");
    do_op(4'h3, 32'd1000, 32'd1000, 1'b0, "after_rst");
    check_idle(1, "after_rst");
  endtask

  task automatic test_random();
    logic [3:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 24; i++) begin
      o = 4'($urandom_range(3, 4));
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 255));
        default: b = $urandom;
      endcase
      do_op(o, a, b, 1'($urandom_range(0, 1)), "random");
      if ($urandom_range(0, 1) == 0) check_idle(1, "random");
    end
    check_idle(1, "random_end");
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    exp_lo = '0;
    exp_hi = '0;
    rst    = 1'b1;
    start  = 1'b0;
    op     = 4'h0;
    x      = '0;
    y      = '0;
    flush  = 1'b0;
    test_reset();
    test_mul();
    test_div();
    test_ignored_op();
    test_start_during_calc();
    test_back_to_back();
    test_flush();
    test_rst_mid_calc();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Iterative multi-cycle multiply/divide unit for the pipeline execute stage; offloads ALU ops 4'h3 (MUL) and 4'h4 (DIV) from single-cycle combinational logic.
- Accepts operands with a start/busy/done handshake and returns lo/hi results (product low/high, or quotient/remainder) to the pipeline's HI/LO write path.
- Hazard logic stalls dependent instructions on busy.

Parameters:
- WIDTH, 32, operand and per-result width.
- CNT_W, 5, iteration counter width; 2**CNT_W must equal WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled on a rising clk edge.
- op  input  4  operation: 4'h3 = unsigned multiply, 4'h4 = unsigned divide; any other value means start is ignored.
- x  input  WIDTH  multiplicand or dividend; sampled with start.
- y  input  WIDTH  multiplier or divisor; sampled with start.
- flush  input  1  synchronous abort from the pipeline (branch or exception).
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse; results valid and updated in this cycle.
- result  output  WIDTH  MUL: product[31:0]; DIV: quotient.
- result2  output  WIDTH  MUL: product[63:32]; DIV: remainder.

Behaviour:
- Reset is asynchronous, one clock, active-high.
  - Applying rst forces state to IDLE and clears counter, internal accumulators, busy, done, result and result2 to 0.
  - Reset is honoured mid-operation; no done is produced for the aborted operation.
- States: IDLE, CALC, DONE.
  - IDLE: busy=0, done=0.
    - start=1 with op 4'h3 or 4'h4 at edge N: latch x, y and op; clear the accumulator; counter=0; go to CALC.
    - start with any other op: stay in IDLE, no output change.
  - CALC: busy=1, done=0.
    - One iteration per edge; the counter increments.
    - The edge that performs iteration with counter=WIDTH-1 moves to DONE and writes result/result2.
    - Iterations occur at edges N+1 through N+32, so done is high in the cycle after edge N+32.
  - DONE: busy=0, done=1 for exactly one cycle.
    - Next edge goes to IDLE, or loads a new operation if a valid start is present (back-to-back accepted).
- start while in CALC is ignored; it is neither queued nor allowed to corrupt operands.
- flush=1 in CALC or DONE: next state IDLE, done suppressed, busy low next cycle.
  - result/result2 keep their previous values.
  - flush and start in the same cycle: flush wins, start is dropped.
- result/result2 hold their last completed values until the next completion or reset. They are never driven to z and never show partial values.
- MUL: shift-add over a 2*WIDTH accumulator.
  - Each iteration: if the current multiplier bit (LSB first) is 1, add the multiplicand shifted to that bit position.
  - Full 64-bit unsigned product; no truncation before the final split.
- DIV: restoring division, MSB first.
  - Each iteration: shift the remainder left, bring in the next dividend bit, trial-subtract the divisor.
  - If the trial result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the bit to 0.
- Divide by zero is defined, not trapped: quotient = all ones (32'hFFFFFFFF), remainder = x.
  - Takes the same 33-cycle latency.
- Latency is fixed at 33 cycles from the accepting edge to the done cycle, independent of operand values. There is no early termination.
- Operands are latched at acceptance; x and y may change freely during CALC.

Test Plan:
- MUL basic: op=3, x=32'd7, y=32'd6 -> busy for 32 cycles; done in cycle 33 after accept; result=32'd42, result2=0.
- MUL full width: x=y=32'hFFFFFFFF -> result=32'h00000001, result2=32'hFFFFFFFE.
- DIV basic and by zero:
  - x=32'd100, y=32'd7 -> result=32'd14, result2=32'd2.
  - x=32'h12345678, y=0 -> result=32'hFFFFFFFF, result2=32'h12345678.
- Handshake:
  - start with op=5 is ignored; busy stays 0.
  - start during CALC with new operands does not alter the in-flight result.
  - start during the DONE cycle is accepted back-to-back and its done arrives 33 cycles later.
- Abort:
  - flush at iteration 10 -> IDLE next cycle, no done, result/result2 keep the prior values.
  - rst asserted mid-CALC and released -> all outputs 0; a subsequent op completes correctly.
